// File: rtl/movseq_pkg.sv
// Shared constants, state encoding and helpers for the MOVZ/MOVK sequencer.
// Optional build macro: MOVSEQ_SKIPZERO_EN (skip zero halfwords).
package movseq_pkg;

    localparam int WORDSIZE = 64;
    localparam int INSW     = 32;

    localparam logic [8:0] OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] OPC_MOVK = 9'b111100101;

    localparam int OPC_LSB = 23;
    localparam int HW_LSB  = 21;
    localparam int IMM_LSB = 5;
    localparam int RD_LSB  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    function automatic logic [INSW-1:0] enc_word(
        input logic        first,
        input logic [1:0]  hw,
        input logic [15:0] imm,
        input logic [4:0]  rd
    );
        logic [INSW-1:0] w;
        w = '0;
        w[OPC_LSB +: 9]  = first ? OPC_MOVZ : OPC_MOVK;
        w[HW_LSB  +: 2]  = hw;
        w[IMM_LSB +: 16] = imm;
        w[RD_LSB  +: 5]  = rd;
        return w;
    endfunction

    // Halfwords still to be emitted for a freshly accepted value.
    function automatic logic [3:0] pending_mask(input logic [WORDSIZE-1:0] v);
        logic [3:0] m;
`ifdef MOVSEQ_SKIPZERO_EN
        for (int i = 0; i < 4; i++) begin
            m[i] = |v[16*i +: 16];
        end
        if (m == 4'b0000) begin
            m = 4'b0001;
        end
`else
        m = 4'b1111;
        if (v == '0) begin
            m = 4'b1111;
        end
`endif
        return m;
    endfunction

endpackage

// File: rtl/movseq_hwpick.sv
// Lowest-set-bit finder over the pending halfword mask; also flags when
// exactly one bit remains.
import movseq_pkg::*;

module movseq_hwpick (
    input  logic [3:0] mask_i,
    output logic [1:0] idx_o,
    output logic       last_o
);

    always_comb begin
        idx_o = 2'd0;
        casez (mask_i)
            4'b???1: idx_o = 2'd0;
            4'b??10: idx_o = 2'd1;
            4'b?100: idx_o = 2'd2;
            4'b1000: idx_o = 2'd3;
            default: idx_o = 2'd0;
        endcase
    end

    assign last_o = (mask_i != 4'b0000) && ((mask_i & (mask_i - 4'd1)) == 4'b0000);

endmodule

// File: rtl/movseq.sv
// Emits the LEGv8 MOVZ/MOVK sequence that rebuilds a 64-bit constant, one word
// per handshake. Optional build macro: MOVSEQ_SKIPZERO_EN.
import movseq_pkg::*;

module movseq (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WORDSIZE-1:0] req_value,
    input  logic [4:0]          req_rd,
    output logic                ins_valid,
    input  logic                ins_ready,
    output logic [INSW-1:0]     ins_word,
    output logic                ins_last
);

    state_e              state_q, state_d;
    logic [WORDSIZE-1:0] value_q, value_d;
    logic [4:0]          rd_q, rd_d;
    logic [3:0]          mask_q, mask_d;
    logic                first_q, first_d;

    logic [1:0]  idx;
    logic        last;
    logic [15:0] hw_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hw
            assign hw_arr[gi] = value_q[16*gi +: 16];
        end
    endgenerate

    movseq_hwpick u_hwpick (
        .mask_i (mask_q),
        .idx_o  (idx),
        .last_o (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            rd_q    <= '0;
            mask_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            rd_q    <= rd_d;
            mask_q  <= mask_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        rd_d    = rd_q;
        mask_d  = mask_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    value_d = req_value;
                    rd_d    = req_rd;
                    mask_d  = pending_mask(req_value);
                    first_d = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (ins_ready) begin
                    mask_d  = mask_q & ~(4'b0001 << idx);
                    first_d = 1'b0;
                    if (last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on req_* directly.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        ins_valid = (state_q == ST_EMIT);
        ins_word  = '0;
        ins_last  = 1'b0;
        if (state_q == ST_EMIT) begin
            ins_word = enc_word(first_q, idx, hw_arr[idx], rd_q);
            ins_last = last;
        end
    end

endmodule

// File: tb/tb_movseq.sv
// Directed bench for movseq; expected words are hand-encoded constants.
// Expectations follow whether MOVSEQ_SKIPZERO_EN is defined for the build.
module tb_movseq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_value;
    logic [4:0]  req_rd;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_word;
    logic        ins_last;

    int total;
    int bad;

    movseq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_value (req_value),
        .req_rd    (req_rd),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_word  (ins_word),
        .ins_last  (ins_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; first word is expected next cycle.
    task automatic send(input logic [63:0] v, input logic [4:0] rd);
        chk("req_ready_before_send", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_value = v;
        req_rd    = rd;
        step();
        req_valid = 1'b0;
    endtask

    // Consume n words; optionally stall `stall_n` cycles in front of word `stall_at`.
    task automatic expect_seq(input string name, input int n,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int stall_at, input int stall_n);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                ins_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    chk($sformatf("%s_stall%0d_valid", name, k), {63'd0, ins_valid}, 64'd1);
                    chk($sformatf("%s_stall%0d_word", name, k), {32'd0, ins_word}, {32'd0, w[i]});
                    chk($sformatf("%s_stall%0d_last", name, k), {63'd0, ins_last}, {63'd0, (i == n-1)});
                    chk($sformatf("%s_stall%0d_reqrdy", name, k), {63'd0, req_ready}, 64'd0);
                    step();
                end
                ins_ready = 1'b1;
            end
            chk($sformatf("%s_w%0d_valid", name, i), {63'd0, ins_valid}, 64'd1);
            chk($sformatf("%s_w%0d_word", name, i), {32'd0, ins_word}, {32'd0, w[i]});
            chk($sformatf("%s_w%0d_last", name, i), {63'd0, ins_last}, {63'd0, (i == n-1)});
            chk($sformatf("%s_w%0d_reqrdy", name, i), {63'd0, req_ready}, 64'd0);
            step();
        end
        req_valid = 1'b0;
        chk($sformatf("%s_end_valid", name), {63'd0, ins_valid}, 64'd0);
        chk($sformatf("%s_end_reqrdy", name), {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_value = '0;
        req_rd    = '0;
        ins_ready = 1'b1;
        step();
        step();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_ins_valid", {63'd0, ins_valid}, 64'd0);
        chk("rst_ins_word", {32'd0, ins_word}, 64'd0);
        chk("rst_ins_last", {63'd0, ins_last}, 64'd0);
        rst_n = 1'b1;
        step();

        // ins_ready high while idle must not start anything
        step();
        chk("idle_ins_valid", {63'd0, ins_valid}, 64'd0);
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // Value 0, Rd 3
        send(64'h0, 5'd3);
`ifdef MOVSEQ_SKIPZERO_EN
        expect_seq("zero", 1, 32'hD2800003, 32'h0, 32'h0, 32'h0, -1, 0);
`else
        expect_seq("zero", 4, 32'hD2800003, 32'hF2A00003, 32'hF2C00003, 32'hF2E00003, -1, 0);
`endif

        // Single nonzero halfword in hw2, Rd 1
        send(64'h0000_1234_0000_0000, 5'd1);
`ifdef MOVSEQ_SKIPZERO_EN
        expect_seq("hw2", 1, 32'hD2C24681, 32'h0, 32'h0, 32'h0, -1, 0);
`else
        expect_seq("hw2", 4, 32'hD2800001, 32'hF2A00001, 32'hF2C24681, 32'hF2E00001, -1, 0);
`endif

        // hw0 and hw3 nonzero, Rd 9, back-to-back
        send(64'hDEAD_0000_0000_BEEF, 5'd9);
`ifdef MOVSEQ_SKIPZERO_EN
        expect_seq("dead", 2, 32'hD297DDE9, 32'hF2FBD5A9, 32'h0, 32'h0, -1, 0);
`else
        expect_seq("dead", 4, 32'hD297DDE9, 32'hF2A00009, 32'hF2C00009, 32'hF2FBD5A9, -1, 0);
`endif

        // Same value, 3-cycle stall on the second word, competing request held high
        send(64'hDEAD_0000_0000_BEEF, 5'd9);
        req_valid = 1'b1;
        req_value = 64'h5555_6666_7777_8888;
        req_rd    = 5'd30;
`ifdef MOVSEQ_SKIPZERO_EN
        expect_seq("stall", 2, 32'hD297DDE9, 32'hF2FBD5A9, 32'h0, 32'h0, 1, 3);
`else
        expect_seq("stall", 4, 32'hD297DDE9, 32'hF2A00009, 32'hF2C00009, 32'hF2FBD5A9, 1, 3);
`endif
        step();
        chk("stall_no_accept_valid", {63'd0, ins_valid}, 64'd0);

        // Reset mid-sequence after the first word
        send(64'hDEAD_0000_0000_BEEF, 5'd9);
        chk("abort_w0_word", {32'd0, ins_word}, 64'hD297DDE9);
        step();
        chk("abort_w1_valid", {63'd0, ins_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ins_valid", {63'd0, ins_valid}, 64'd0);
        chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_ins_word", {32'd0, ins_word}, 64'd0);
        chk("abort_ins_last", {63'd0, ins_last}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        send(64'h0, 5'd3);
`ifdef MOVSEQ_SKIPZERO_EN
        expect_seq("fresh", 1, 32'hD2800003, 32'h0, 32'h0, 32'h0, -1, 0);
`else
        expect_seq("fresh", 4, 32'hD2800003, 32'hF2A00003, 32'hF2C00003, 32'hF2E00003, -1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/movseq.md
# movseq

Constant materializer: takes a 64-bit value and a destination register number and emits the LEGv8 MOVZ/MOVK instruction sequence that rebuilds that value, one 32-bit instruction word per handshake. It is the encoding-side counterpart of the MOV datapath, which composes a register value from MOVZ/MOVK halfwords. It sits between the boot/constant loader and instruction memory, and also feeds the core's self-test instruction stream.

## Interface
- No parameters; widths come from `WORDSIZE` (64) in bus.vh and a fixed 32-bit instruction width.
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — block can accept a request.
- `req_value` in 64 — constant to materialize.
- `req_rd` in 5 — destination register Rd.
- `ins_valid` out 1 — `ins_word` holds a valid instruction.
- `ins_ready` in 1 — consumer accepts `ins_word`.
- `ins_word` out 32 — encoded instruction {opcode[8:0], hw[1:0], imm16, Rd}.
- `ins_last` out 1 — current word is the final one of the sequence.

## Operation
- States: IDLE and EMIT.
- IDLE:
  - `req_ready`=1 and `ins_valid`=0.
  - On `req_valid`&&`req_ready`, latch value and Rd, compute the pending-halfword mask, go to EMIT.
- Pending mask: bit i set iff halfword i (value[16i+15:16i]) is nonzero.
  - If the mask is empty, use mask 4'b0001, so a single MOVZ #0 is emitted.
- EMIT:
  - Current halfword index = lowest set bit of the pending mask.
  - The first word of a sequence is MOVZ (opcode 9'b110100101). Later words are MOVK (9'b111100101).
  - Field mapping: hw = index, imm16 = that halfword, Rd = latched Rd.
- On `ins_valid`&&`ins_ready`:
  - Clear the index bit.
  - If the mask is now empty, return to IDLE. Otherwise stay in EMIT with the next index.
- `ins_last` = exactly one pending bit remains.
- Halfwords are emitted in ascending index order.
- A sequence is 1–4 words long.

## Timing
- Reset values: state IDLE, `req_ready`=1, `ins_valid`=0, `ins_word`=0, `ins_last`=0. All internal registers are cleared.
- Latency: request accepted at edge N gives the first word valid after edge N (cycle N+1). No combinational path from `req_*` to `ins_*`.
- Throughput: one word per cycle while `ins_ready`=1. The last word leaves at edge M, and `req_ready` rises in cycle M+1.
- Backpressure: while `ins_valid`=1 and `ins_ready`=0, `ins_word` and `ins_last` stay stable.
- `ins_valid` never drops without a handshake.
- `req_ready` is 0 throughout EMIT. No overlap between requests.
- `ins_ready` asserted while `ins_valid`=0 has no effect.
- Reset asserted mid-sequence aborts it immediately. No partial word is retained after reset deasserts.

## Configuration
- `MOVSEQ_SKIPZERO_EN` defined:
  - Zero halfwords are skipped as described in Operation.
  - The first emitted word is MOVZ at the lowest nonzero halfword.
- Undefined:
  - The mask is forced to 4'b1111 every request.
  - Output is always 4 words: MOVZ hw0, then MOVK hw1, hw2, hw3, including zero immediates.
  - `ins_last` is on the hw3 word.

## Structure
- opcode.vh holds:
  - the 9-bit MOVZ/MOVK prefixes;
  - the field positions (opcode [31:23], hw [22:21], imm [20:5], Rd [4:0]);
  - the state encodings.
- bus.vh supplies `WORDSIZE`.
- One sub-module, `hwpick`: combinational lowest-set-bit finder over the 4-bit pending mask. Outputs index[1:0] and a `last` flag.
- Estimated size: about 150 lines of RTL.

## Test plan
- Value 0, Rd 3 → one word 0xD2800003 with `ins_last`=1. `req_ready` returns the cycle after.
- Value 0x0000_1234_0000_0000, Rd 1, SKIPZERO on → single word 0xD2C24681, last=1.
- Value 0xDEAD_0000_0000_BEEF, Rd 9, SKIPZERO on → 0xD297DDE9 then 0xF2FBD5A9 (last). `ins_ready` held high gives back-to-back cycles.
- Same value, SKIPZERO off → 0xD297DDE9, 0xF2A00009, 0xF2C00009, 0xF2FBD5A9, with last only on the fourth word.
- Drop `ins_ready` for 3 cycles on the second word → word and last held stable, no word skipped or duplicated. `req_valid` held high during EMIT is not accepted.
- Assert `rst_n`=0 after the first word of a 4-word sequence → `ins_valid`=0 and `req_ready`=1 immediately. The next request starts fresh with MOVZ.
